word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer_pkg.sv | 13 +
 rtl/word_serializer.sv | 91 +++++++++
 tb/tb_word_serializer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared widths and FSM state encodings for the 16-to-8 word serializer.
package word_serializer_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FIRST  = 2'b01,
    SECOND = 2'b10
  } state_e;

endpackage

// File: rtl/word_serializer.sv
// Splits each accepted 16-bit word into two bytes on a valid/ready stream and
// counts fully sent words. Byte order is selected by LOW_FIRST.
//
//   state  | meaning
//   IDLE   | no word held, input side open
//   FIRST  | presenting first byte of the held word
//   SECOND | presenting second byte; may accept the next word in the same cycle
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [WORD_W-1:0] word_count
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic [BYTE_W-1:0] first_byte, second_byte;

  assign first_byte  = LOW_FIRST ? hold_q[BYTE_W-1:0] : hold_q[WORD_W-1:BYTE_W];
  assign second_byte = LOW_FIRST ? hold_q[WORD_W-1:BYTE_W] : hold_q[BYTE_W-1:0];
  assign word_count  = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = '0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = in_word;
          state_d = FIRST;
        end
      end
      FIRST: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_byte  = first_byte;
        if (out_ready) state_d = SECOND;
      end
      SECOND: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        busy      = 1'b1;
        out_byte  = second_byte;
        // Opening the input while the last byte drains keeps one byte per cycle.
        in_ready  = out_ready;
        if (out_ready) begin
          count_d = count_q + 16'd1;
          if (in_valid) begin
            hold_d  = in_word;
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed vector table, reset and
// counter-wrap sequences, then random traffic against a byte-queue model.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir_lo, ov_lo, last_lo, busy_lo;
  logic [7:0]  byte_lo;
  logic [15:0] cnt_lo;
  logic        ir_hi, ov_hi, last_hi, busy_hi;
  logic [7:0]  byte_hi;
  logic [15:0] cnt_hi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  word_serializer #(.LOW_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .in_ready(ir_lo), .out_byte(byte_lo), .out_valid(ov_lo),
    .out_ready(out_ready), .out_last(last_lo), .busy(busy_lo),
    .word_count(cnt_lo)
  );

  word_serializer #(.LOW_FIRST(1'b0)) u_dut_hf (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .in_ready(ir_hi), .out_byte(byte_hi), .out_valid(ov_hi),
    .out_ready(out_ready), .out_last(last_hi), .busy(busy_hi),
    .word_count(cnt_hi)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes still owed downstream, in send order, per byte order.
  logic [7:0]  q_lo[$];
  logic [7:0]  q_hi[$];
  logic [15:0] m_cnt = '0;

  function automatic logic m_in_ready();
    return (q_lo.size() == 0) || (q_lo.size() == 1 && out_ready);
  endfunction

  task automatic check_model();
    logic ov;
    ov = (q_lo.size() != 0);
    chk("m_out_valid", ov_lo, ov);
    chk("m_out_valid_hf", ov_hi, ov);
    chk("m_in_ready", ir_lo, m_in_ready());
    chk("m_in_ready_hf", ir_hi, m_in_ready());
    chk("m_busy", busy_lo, ov);
    chk("m_busy_hf", busy_hi, ov);
    chk("m_word_count", cnt_lo, m_cnt);
    chk("m_word_count_hf", cnt_hi, m_cnt);
    if (ov) begin
      chk("m_out_last", last_lo, q_lo.size() == 1);
      chk("m_out_last_hf", last_hi, q_hi.size() == 1);
      chk("m_out_byte", byte_lo, q_lo[0]);
      chk("m_out_byte_hf", byte_hi, q_hi[0]);
    end
  endtask

  task automatic model_edge(input logic iv, input logic [15:0] w, input logic ordy);
    logic accept;
    accept = iv && m_in_ready();
    if (q_lo.size() != 0 && ordy) begin
      if (q_lo.size() == 1) m_cnt = m_cnt + 16'd1;
      void'(q_lo.pop_front());
      void'(q_hi.pop_front());
    end
    if (accept) begin
      q_lo.push_back(w[7:0]);  q_lo.push_back(w[15:8]);
      q_hi.push_back(w[15:8]); q_hi.push_back(w[7:0]);
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] w, input logic ordy);
    @(negedge clk);
    in_valid = iv; in_word = w; out_ready = ordy;
    #1;
    check_model();
    @(posedge clk);
    model_edge(iv, w, ordy);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    q_lo.delete(); q_hi.delete(); m_cnt = '0;
    chk("rst_out_valid", ov_lo, 1'b0);
    chk("rst_out_last", last_lo, 1'b0);
    chk("rst_out_byte", byte_lo, 8'h00);
    chk("rst_busy", busy_lo, 1'b0);
    chk("rst_word_count", cnt_lo, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", ir_lo, 1'b1);
  endtask

  typedef struct {
    logic        iv;
    logic [15:0] w;
    logic        ordy;
    logic        ov;
    logic [7:0]  b_lo;
    logic [7:0]  b_hi;
    logic        last;
    logic        ir;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic iv, input logic [15:0] w, input logic ordy,
                     input logic ov, input logic [7:0] bl, input logic [7:0] bh,
                     input logic last, input logic ir, input logic bz,
                     input logic [15:0] cnt);
    vec_t v;
    v.iv = iv; v.w = w; v.ordy = ordy; v.ov = ov; v.b_lo = bl; v.b_hi = bh;
    v.last = last; v.ir = ir; v.busy = bz; v.cnt = cnt;
    vt.push_back(v);
  endtask

  initial begin
    // single word A55A, then 1234 (byte order per instance)
    add(1, 16'hA55A, 1,  0, 8'h00, 8'h00, 0, 1, 0, 16'd0);
    add(0, 16'h0000, 1,  1, 8'h5A, 8'hA5, 0, 0, 1, 16'd0);
    add(0, 16'h0000, 1,  1, 8'hA5, 8'h5A, 1, 1, 1, 16'd0);
    add(0, 16'h0000, 1,  0, 8'h00, 8'h00, 0, 1, 0, 16'd1);
    add(1, 16'h1234, 1,  0, 8'h00, 8'h00, 0, 1, 0, 16'd1);
    add(0, 16'h0000, 1,  1, 8'h34, 8'h12, 0, 0, 1, 16'd1);
    add(0, 16'h0000, 1,  1, 8'h12, 8'h34, 1, 1, 1, 16'd1);
    // CAFE with five stalled cycles in FIRST; DEAD offered meanwhile
    add(1, 16'hCAFE, 0,  0, 8'h00, 8'h00, 0, 1, 0, 16'd2);
    for (int i = 0; i < 5; i++)
      add(1, 16'hDEAD, 0, 1, 8'hFE, 8'hCA, 0, 0, 1, 16'd2);
    add(1, 16'hDEAD, 1,  1, 8'hFE, 8'hCA, 0, 0, 1, 16'd2);
    add(0, 16'h0000, 1,  1, 8'hCA, 8'hFE, 1, 1, 1, 16'd2);
    // stall in SECOND: in_ready follows out_ready, 0BAD ignored
    add(1, 16'h0102, 1,  0, 8'h00, 8'h00, 0, 1, 0, 16'd3);
    add(0, 16'h0000, 1,  1, 8'h02, 8'h01, 0, 0, 1, 16'd3);
    add(1, 16'h0BAD, 0,  1, 8'h01, 8'h02, 1, 0, 1, 16'd3);
    add(0, 16'h0000, 1,  1, 8'h01, 8'h02, 1, 1, 1, 16'd3);
    // back-to-back 00FF, FF00, BEEF
    add(1, 16'h00FF, 1,  0, 8'h00, 8'h00, 0, 1, 0, 16'd4);
    add(1, 16'hFF00, 1,  1, 8'hFF, 8'h00, 0, 0, 1, 16'd4);
    add(1, 16'hFF00, 1,  1, 8'h00, 8'hFF, 1, 1, 1, 16'd4);
    add(1, 16'hBEEF, 1,  1, 8'h00, 8'hFF, 0, 0, 1, 16'd5);
    add(1, 16'hBEEF, 1,  1, 8'hFF, 8'h00, 1, 1, 1, 16'd5);
    add(0, 16'h0000, 1,  1, 8'hEF, 8'hBE, 0, 0, 1, 16'd6);
    add(0, 16'h0000, 1,  1, 8'hBE, 8'hEF, 1, 1, 1, 16'd6);
    add(0, 16'h0000, 1,  0, 8'h00, 8'h00, 0, 1, 0, 16'd7);

    // power-on reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("por_out_valid", ov_lo, 1'b0);
    chk("por_out_last", last_lo, 1'b0);
    chk("por_out_byte", byte_lo, 8'h00);
    chk("por_busy", busy_lo, 1'b0);
    chk("por_word_count", cnt_lo, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("por_in_ready", ir_lo, 1'b1);

    foreach (vt[i]) begin
      @(negedge clk);
      in_valid = vt[i].iv; in_word = vt[i].w; out_ready = vt[i].ordy;
      #1;
      chk($sformatf("vec%0d_out_valid", i), ov_lo, vt[i].ov);
      chk($sformatf("vec%0d_in_ready", i), ir_lo, vt[i].ir);
      chk($sformatf("vec%0d_busy", i), busy_lo, vt[i].busy);
      chk($sformatf("vec%0d_word_count", i), cnt_lo, vt[i].cnt);
      chk($sformatf("vec%0d_out_last", i), last_lo, vt[i].last);
      chk($sformatf("vec%0d_out_last_hf", i), last_hi, vt[i].last);
      chk($sformatf("vec%0d_out_byte", i), byte_lo, vt[i].b_lo);
      chk($sformatf("vec%0d_out_byte_hf", i), byte_hi, vt[i].b_hi);
    end

    // reset while in SECOND of 0x1111 drops the word; 0x2222 follows cleanly
    apply_reset();
    step(1'b1, 16'h1111, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    #1;
    chk("mid_pre_last", last_lo, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", ov_lo, 1'b0);
    chk("mid_rst_word_count", cnt_lo, 16'h0000);
    q_lo.delete(); q_hi.delete(); m_cnt = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 16'h2222, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    chk("mid_after_count", cnt_lo, 16'h0001);

    // word_count wrap: preload 0xFFFF while idle, then send one word
    @(negedge clk);
    force u_dut.count_q = 16'hFFFF;
    force u_dut_hf.count_q = 16'hFFFF;
    @(negedge clk);
    release u_dut.count_q;
    release u_dut_hf.count_q;
    m_cnt = 16'hFFFF;
    step(1'b1, 16'h5AA5, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    chk("wrap_word_count", cnt_lo, 16'h0000);
    chk("wrap_word_count_hf", cnt_hi, 16'h0000);

    // random traffic against the model
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 16'($urandom),
             1'($urandom_range(0, 3) != 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
